// File: rtl/bgpu_pkg.sv
// Shared types for the warp allocation path: id, pc, address, block and group widths.
// warp_init_t bundles the fields handed to the warp table on an init pulse.
package bgpu_pkg;

  localparam int DefNumWarps      = 8;
  localparam int DefPcWidth       = 16;
  localparam int DefAddressWidth  = 32;
  localparam int DefTblockIdxBits = 5;
  localparam int DefTblockSzBits  = 6;
  localparam int DefTgroupIdBits  = 8;
  localparam int DefWidBits       = $clog2(DefNumWarps);

  typedef logic [DefWidBits-1:0]       warp_id_t;
  typedef logic [DefPcWidth-1:0]       pc_t;
  typedef logic [DefAddressWidth-1:0]  addr_t;
  typedef logic [DefTblockIdxBits-1:0] tblock_idx_t;
  typedef logic [DefTblockSzBits-1:0]  tblock_size_t;
  typedef logic [DefTgroupIdBits-1:0]  tgroup_id_t;

  typedef struct packed {
    warp_id_t     warp_id;
    pc_t          pc;
    addr_t        dp_addr;
    tblock_size_t tblock_size;
    tblock_idx_t  tblock_idx;
    tgroup_id_t   tgroup_id;
  } warp_init_t;

endpackage

// File: rtl/warp_slot_picker.sv
// Combinational free-slot selector: first clear bit of active at or after ptr (wrapping).
// Ports: active (bitmap), ptr (search start) -> sel (slot), any_free (some bit clear).
module warp_slot_picker #(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] active,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] sel,
  output logic         any_free
);

  int   idx;
  logic found;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      if (!found && !active[idx]) begin
        found = 1'b1;
        sel   = W'(idx);
      end
    end
  end

  assign any_free = ~&active;

endmodule

// File: rtl/warp_allocator.sv
// Binds dispatcher requests to free warp slots and emits a registered init pulse.
// Ports: allocate_* request (valid/ready via warp_free_o), init_* pulse out,
// warp_done_* retire in, warp_active_o / active_warps_o status.
// Macro WARP_ALLOCATOR_ROUND_ROBIN_EN selects round-robin instead of lowest-index.
module warp_allocator
  import bgpu_pkg::*;
#(
  parameter int NumWarps       = DefNumWarps,
  parameter int PcWidth        = DefPcWidth,
  parameter int AddressWidth   = DefAddressWidth,
  parameter int TblockIdxBits  = DefTblockIdxBits,
  parameter int TblockSizeBits = DefTblockSzBits,
  parameter int TgroupIdBits   = DefTgroupIdBits,
  localparam int WidBits       = $clog2(NumWarps),
  localparam int CntBits       = $clog2(NumWarps + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      allocate_warp_i,
  output logic                      warp_free_o,
  input  logic [PcWidth-1:0]        allocate_pc_i,
  input  logic [AddressWidth-1:0]   allocate_dp_addr_i,
  input  logic [TblockSizeBits-1:0] allocate_tblock_size_i,
  input  logic [TblockIdxBits-1:0]  allocate_tblock_idx_i,
  input  logic [TgroupIdBits-1:0]   allocate_tgroup_id_i,
  output logic                      init_valid_o,
  output logic [WidBits-1:0]        init_warp_id_o,
  output logic [PcWidth-1:0]        init_pc_o,
  output logic [AddressWidth-1:0]   init_dp_addr_o,
  output logic [TblockSizeBits-1:0] init_tblock_size_o,
  output logic [TblockIdxBits-1:0]  init_tblock_idx_o,
  output logic [TgroupIdBits-1:0]   init_tgroup_id_o,
  input  logic                      warp_done_i,
  input  logic [WidBits-1:0]        warp_done_id_i,
  output logic [NumWarps-1:0]       warp_active_o,
  output logic [CntBits-1:0]        active_warps_o
);

  logic [NumWarps-1:0] active_q, active_d;
  logic [CntBits-1:0]  active_cnt_q, cnt_d;
  logic [WidBits-1:0]  sel, ptr;
  logic                any_free, hs, done_ok;
  logic                init_valid_q;
  warp_init_t          init_q;

  warp_slot_picker #(.N(NumWarps)) u_picker (
    .active   (active_q),
    .ptr      (ptr),
    .sel      (sel),
    .any_free (any_free)
  );

  assign warp_free_o = any_free;
  assign hs          = allocate_warp_i && any_free;
  // Out-of-range or already-free retires must not touch state.
  assign done_ok = warp_done_i
                && (int'(warp_done_id_i) < NumWarps)
                && active_q[warp_done_id_i];

  always_comb begin
    active_d = active_q;
    cnt_d    = active_cnt_q;
    if (done_ok) active_d[warp_done_id_i] = 1'b0;
    if (hs) active_d[sel] = 1'b1;
    case ({hs, done_ok})
      2'b10:   cnt_d = active_cnt_q + CntBits'(1);
      2'b01:   cnt_d = active_cnt_q - CntBits'(1);
      default: cnt_d = active_cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q     <= '0;
      active_cnt_q <= '0;
      init_valid_q <= 1'b0;
      init_q       <= '0;
    end else begin
      active_q     <= active_d;
      active_cnt_q <= cnt_d;
      init_valid_q <= hs;
      if (hs) begin
        init_q.warp_id     <= sel;
        init_q.pc          <= allocate_pc_i;
        init_q.dp_addr     <= allocate_dp_addr_i;
        init_q.tblock_size <= allocate_tblock_size_i;
        init_q.tblock_idx  <= allocate_tblock_idx_i;
        init_q.tgroup_id   <= allocate_tgroup_id_i;
      end
    end
  end

`ifdef WARP_ALLOCATOR_ROUND_ROBIN_EN
  logic [WidBits-1:0] rr_ptr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_q <= '0;
    end else if (hs) begin
      rr_ptr_q <= (int'(sel) == NumWarps - 1) ? '0 : sel + 1'b1;
    end
  end

  assign ptr = rr_ptr_q;
`else
  assign ptr = '0;
`endif

  assign init_valid_o       = init_valid_q;
  assign init_warp_id_o     = init_q.warp_id;
  assign init_pc_o          = init_q.pc;
  assign init_dp_addr_o     = init_q.dp_addr;
  assign init_tblock_size_o = init_q.tblock_size;
  assign init_tblock_idx_o  = init_q.tblock_idx;
  assign init_tgroup_id_o   = init_q.tgroup_id;
  assign warp_active_o      = active_q;
  assign active_warps_o     = active_cnt_q;

`ifndef SYNTHESIS
  a_no_hs_full: assert property (
    @(posedge clk_i) disable iff (!rst_ni) hs |-> !(&active_q))
    else $error("handshake while all slots active");

  a_done_free: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    (warp_done_i && int'(warp_done_id_i) < NumWarps) |-> active_q[warp_done_id_i])
    else $warning("retire for slot %0d which is not active", warp_done_id_i);

  a_cnt: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    int'(active_cnt_q) == $countones(active_q))
    else $error("active count disagrees with bitmap");
`endif

endmodule

// File: tb/tb_warp_allocator.sv
// Directed and randomized checks of warp_allocator against a small reference model.
// Optional round-robin expectations follow WARP_ALLOCATOR_ROUND_ROBIN_EN.
module tb_warp_allocator;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        allocate_warp_i = 1'b0;
  logic        warp_free_o;
  logic [15:0] allocate_pc_i = '0;
  logic [31:0] allocate_dp_addr_i = '0;
  logic [5:0]  allocate_tblock_size_i = '0;
  logic [4:0]  allocate_tblock_idx_i = '0;
  logic [7:0]  allocate_tgroup_id_i = '0;
  logic        init_valid_o;
  logic [2:0]  init_warp_id_o;
  logic [15:0] init_pc_o;
  logic [31:0] init_dp_addr_o;
  logic [5:0]  init_tblock_size_o;
  logic [4:0]  init_tblock_idx_o;
  logic [7:0]  init_tgroup_id_o;
  logic        warp_done_i = 1'b0;
  logic [2:0]  warp_done_id_i = '0;
  logic [7:0]  warp_active_o;
  logic [3:0]  active_warps_o;

  int vec  = 0;
  int errs = 0;

  warp_allocator dut (
    .clk_i                  (clk_i),
    .rst_ni                 (rst_ni),
    .allocate_warp_i        (allocate_warp_i),
    .warp_free_o            (warp_free_o),
    .allocate_pc_i          (allocate_pc_i),
    .allocate_dp_addr_i     (allocate_dp_addr_i),
    .allocate_tblock_size_i (allocate_tblock_size_i),
    .allocate_tblock_idx_i  (allocate_tblock_idx_i),
    .allocate_tgroup_id_i   (allocate_tgroup_id_i),
    .init_valid_o           (init_valid_o),
    .init_warp_id_o         (init_warp_id_o),
    .init_pc_o              (init_pc_o),
    .init_dp_addr_o         (init_dp_addr_o),
    .init_tblock_size_o     (init_tblock_size_o),
    .init_tblock_idx_o      (init_tblock_idx_o),
    .init_tgroup_id_o       (init_tgroup_id_o),
    .warp_done_i            (warp_done_i),
    .warp_done_id_i         (warp_done_id_i),
    .warp_active_o          (warp_active_o),
    .active_warps_o         (active_warps_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    allocate_warp_i = 1'b0;
    warp_done_i     = 1'b0;
    rst_ni          = 1'b0;
    step();
    rst_ni = 1'b1;
  endtask

  function automatic logic [2:0] pick(input logic [7:0] a, input logic [2:0] p);
    logic [2:0] k;
    pick = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      k = p + 3'(i);
      if (!a[k]) pick = k;
    end
  endfunction

  task automatic test_reset();
    rst_ni = 1'b0;
    repeat (2) step();
    vec++; if (warp_free_o !== 1'b1) begin errs++; $display("FAIL rst_free got=%b want=1", warp_free_o); end
    vec++; if (init_valid_o !== 1'b0) begin errs++; $display("FAIL rst_valid got=%b want=0", init_valid_o); end
    vec++; if (warp_active_o !== 8'h00) begin errs++; $display("FAIL rst_active got=%h want=00", warp_active_o); end
    vec++; if (active_warps_o !== 4'd0) begin errs++; $display("FAIL rst_count got=%0d want=0", active_warps_o); end
    vec++; if ({init_warp_id_o, init_pc_o, init_dp_addr_o} !== 51'd0) begin
      errs++; $display("FAIL rst_init_data got=%h/%h/%h want=0", init_warp_id_o, init_pc_o, init_dp_addr_o);
    end
    vec++; if ({init_tblock_size_o, init_tblock_idx_o, init_tgroup_id_o} !== 19'd0) begin
      errs++; $display("FAIL rst_init_blk got=%h/%h/%h want=0", init_tblock_size_o, init_tblock_idx_o, init_tgroup_id_o);
    end
    rst_ni = 1'b1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      allocate_warp_i        = 1'b1;
      allocate_pc_i          = 16'(16'h1000 + i);
      allocate_dp_addr_i     = 32'(32'hA000_0000 + i);
      allocate_tblock_size_i = 6'(i + 1);
      allocate_tblock_idx_i  = 5'(i);
      allocate_tgroup_id_i   = 8'(8'h10 + i);
      vec++; if (warp_free_o !== 1'b1) begin errs++; $display("FAIL b2b_free[%0d] got=%b want=1", i, warp_free_o); end
      step();
      vec++; if (init_valid_o !== 1'b1) begin errs++; $display("FAIL b2b_valid[%0d] got=%b want=1", i, init_valid_o); end
      vec++; if (init_warp_id_o !== 3'(i)) begin errs++; $display("FAIL b2b_id[%0d] got=%0d want=%0d", i, init_warp_id_o, i); end
      vec++; if (init_tblock_idx_o !== 5'(i)) begin errs++; $display("FAIL b2b_idx[%0d] got=%0d want=%0d", i, init_tblock_idx_o, i); end
      vec++; if (init_pc_o !== 16'(16'h1000 + i) || init_dp_addr_o !== 32'(32'hA000_0000 + i)) begin
        errs++; $display("FAIL b2b_pcdp[%0d] got=%h/%h want=%h/%h", i, init_pc_o, init_dp_addr_o, 16'(16'h1000 + i), 32'(32'hA000_0000 + i));
      end
      vec++; if (init_tblock_size_o !== 6'(i + 1) || init_tgroup_id_o !== 8'(8'h10 + i)) begin
        errs++; $display("FAIL b2b_sztg[%0d] got=%h/%h want=%h/%h", i, init_tblock_size_o, init_tgroup_id_o, 6'(i + 1), 8'(8'h10 + i));
      end
    end
    vec++; if (warp_free_o !== 1'b0) begin errs++; $display("FAIL b2b_full_free got=%b want=0", warp_free_o); end
    vec++; if (warp_active_o !== 8'hFF) begin errs++; $display("FAIL b2b_full_map got=%h want=ff", warp_active_o); end
    vec++; if (active_warps_o !== 4'd8) begin errs++; $display("FAIL b2b_full_cnt got=%0d want=8", active_warps_o); end
  endtask

  task automatic test_full_done();
    allocate_warp_i        = 1'b1;
    allocate_pc_i          = 16'hBEEF;
    allocate_dp_addr_i     = 32'hDEAD_0005;
    allocate_tblock_size_i = 6'd3;
    allocate_tblock_idx_i  = 5'd9;
    allocate_tgroup_id_i   = 8'h5A;
    step();
    vec++; if (init_valid_o !== 1'b0) begin errs++; $display("FAIL full_hold_valid got=%b want=0", init_valid_o); end
    vec++; if (init_warp_id_o !== 3'd7 || init_pc_o !== 16'h1007) begin
      errs++; $display("FAIL full_hold_data got=%0d/%h want=7/1007", init_warp_id_o, init_pc_o);
    end
    warp_done_i    = 1'b1;
    warp_done_id_i = 3'd5;
    step();
    warp_done_i = 1'b0;
    vec++; if (warp_free_o !== 1'b1) begin errs++; $display("FAIL full_done_free got=%b want=1", warp_free_o); end
    vec++; if (warp_active_o !== 8'hDF) begin errs++; $display("FAIL full_done_map got=%h want=df", warp_active_o); end
    vec++; if (init_valid_o !== 1'b0) begin errs++; $display("FAIL full_done_valid got=%b want=0", init_valid_o); end
    step();
    allocate_warp_i = 1'b0;
    vec++; if (init_valid_o !== 1'b1 || init_warp_id_o !== 3'd5) begin
      errs++; $display("FAIL full_reuse_id got=%b/%0d want=1/5", init_valid_o, init_warp_id_o);
    end
    vec++; if (init_pc_o !== 16'hBEEF || init_tgroup_id_o !== 8'h5A) begin
      errs++; $display("FAIL full_reuse_data got=%h/%h want=beef/5a", init_pc_o, init_tgroup_id_o);
    end
    vec++; if (warp_free_o !== 1'b0 || active_warps_o !== 4'd8) begin
      errs++; $display("FAIL full_reuse_state got=%b/%0d want=0/8", warp_free_o, active_warps_o);
    end
  endtask

  task automatic test_simul_alloc_done();
    warp_done_i    = 1'b1;
    warp_done_id_i = 3'd3;
    step();
    vec++; if (warp_active_o !== 8'hF7 || active_warps_o !== 4'd7) begin
      errs++; $display("FAIL sim_pre got=%h/%0d want=f7/7", warp_active_o, active_warps_o);
    end
    allocate_warp_i      = 1'b1;
    allocate_pc_i        = 16'h3333;
    allocate_tgroup_id_i = 8'h33;
    warp_done_id_i       = 3'd1;
    step();
    allocate_warp_i = 1'b0;
    warp_done_i     = 1'b0;
    vec++; if (active_warps_o !== 4'd7) begin errs++; $display("FAIL sim_cnt got=%0d want=7", active_warps_o); end
    vec++; if (warp_active_o !== 8'hFD) begin errs++; $display("FAIL sim_map got=%h want=fd", warp_active_o); end
    vec++; if (init_valid_o !== 1'b1 || init_warp_id_o !== 3'd3) begin
      errs++; $display("FAIL sim_init got=%b/%0d want=1/3", init_valid_o, init_warp_id_o);
    end
  endtask

  task automatic test_spurious_done();
    warp_done_i    = 1'b1;
    warp_done_id_i = 3'd2;
    step();
    vec++; if (warp_active_o !== 8'hF9 || active_warps_o !== 4'd6) begin
      errs++; $display("FAIL spur_pre got=%h/%0d want=f9/6", warp_active_o, active_warps_o);
    end
    step();
    warp_done_i = 1'b0;
    vec++; if (warp_active_o !== 8'hF9 || active_warps_o !== 4'd6) begin
      errs++; $display("FAIL spur_map got=%h/%0d want=f9/6", warp_active_o, active_warps_o);
    end
    vec++; if (init_valid_o !== 1'b0) begin errs++; $display("FAIL spur_valid got=%b want=0", init_valid_o); end
  endtask

  task automatic test_reuse_order();
    logic [2:0] want;
`ifdef WARP_ALLOCATOR_ROUND_ROBIN_EN
    want = 3'd2;
`else
    want = 3'd0;
`endif
    rst_ni = 1'b0;
    #1;
    vec++; if (warp_active_o !== 8'h00 || warp_free_o !== 1'b1) begin
      errs++; $display("FAIL midrst got=%h/%b want=00/1", warp_active_o, warp_free_o);
    end
    step();
    rst_ni = 1'b1;
    allocate_warp_i = 1'b1;
    step();
    step();
    allocate_warp_i = 1'b0;
    vec++; if (init_warp_id_o !== 3'd1 || warp_active_o !== 8'h03) begin
      errs++; $display("FAIL order_pre got=%0d/%h want=1/03", init_warp_id_o, warp_active_o);
    end
    warp_done_i    = 1'b1;
    warp_done_id_i = 3'd0;
    step();
    warp_done_i     = 1'b0;
    allocate_warp_i = 1'b1;
    step();
    allocate_warp_i = 1'b0;
    vec++; if (init_valid_o !== 1'b1 || init_warp_id_o !== want) begin
      errs++; $display("FAIL order_id got=%b/%0d want=1/%0d", init_valid_o, init_warp_id_o, want);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    allocate_warp_i = 1'b1;
    repeat (8) step();
    allocate_warp_i = 1'b0;
    vec++; if (init_warp_id_o !== 3'd7 || warp_active_o !== 8'hFF) begin
      errs++; $display("FAIL wrap_fill got=%0d/%h want=7/ff", init_warp_id_o, warp_active_o);
    end
    warp_done_i    = 1'b1;
    warp_done_id_i = 3'd6;
    step();
    warp_done_i     = 1'b0;
    allocate_warp_i = 1'b1;
    step();
    allocate_warp_i = 1'b0;
    vec++; if (init_warp_id_o !== 3'd6) begin errs++; $display("FAIL wrap_six got=%0d want=6", init_warp_id_o); end
    warp_done_i    = 1'b1;
    warp_done_id_i = 3'd0;
    step();
    warp_done_id_i = 3'd2;
    step();
    warp_done_i     = 1'b0;
    allocate_warp_i = 1'b1;
    step();
    vec++; if (init_valid_o !== 1'b1 || init_warp_id_o !== 3'd0) begin
      errs++; $display("FAIL wrap_zero got=%b/%0d want=1/0", init_valid_o, init_warp_id_o);
    end
    step();
    allocate_warp_i = 1'b0;
    vec++; if (init_warp_id_o !== 3'd2 || warp_active_o !== 8'hFF) begin
      errs++; $display("FAIL wrap_two got=%0d/%h want=2/ff", init_warp_id_o, warp_active_o);
    end
  endtask

  task automatic test_stress();
    logic [7:0]  m_act, m_prev;
    logic [2:0]  m_ptr, sel;
    logic        a, d, hs, hold;
    logic [2:0]  did;
    logic [15:0] r_pc;
    logic [31:0] r_dp;
    logic [5:0]  r_sz;
    logic [4:0]  r_ix;
    logic [7:0]  r_tg;
    int          reqs, cyc;
    do_reset();
    m_act = '0; m_ptr = '0; hold = 1'b0; reqs = 0; cyc = 0;
    a = 1'b0; r_pc = '0; r_dp = '0; r_sz = '0; r_ix = '0; r_tg = '0;
    while (reqs < 1000 && cyc < 20000) begin
      if (!hold) begin
        a    = ($urandom_range(0, 3) != 0);
        r_pc = 16'($urandom);
        r_dp = $urandom;
        r_sz = 6'($urandom);
        r_ix = 5'($urandom);
        r_tg = 8'($urandom);
      end
      d   = ($urandom_range(0, 2) == 0);
      did = 3'($urandom_range(0, 7));
      if (!m_act[did]) d = 1'b0;
      allocate_warp_i        = a;
      allocate_pc_i          = r_pc;
      allocate_dp_addr_i     = r_dp;
      allocate_tblock_size_i = r_sz;
      allocate_tblock_idx_i  = r_ix;
      allocate_tgroup_id_i   = r_tg;
      warp_done_i            = d;
      warp_done_id_i         = did;
      hs  = a && !(&m_act);
      sel = pick(m_act, m_ptr);
      m_prev = m_act;
      step();
      if (d) m_act[did] = 1'b0;
      if (hs) begin
        m_act[sel] = 1'b1;
`ifdef WARP_ALLOCATOR_ROUND_ROBIN_EN
        m_ptr = sel + 3'd1;
`endif
        reqs++;
      end
      vec++; if (init_valid_o !== hs) begin errs++; $display("FAIL st_valid c%0d got=%b want=%b", cyc, init_valid_o, hs); end
      if (hs) begin
        vec++; if (init_warp_id_o !== sel) begin errs++; $display("FAIL st_id c%0d got=%0d want=%0d", cyc, init_warp_id_o, sel); end
        vec++; if (m_prev[init_warp_id_o] !== 1'b0) begin errs++; $display("FAIL st_double c%0d slot=%0d", cyc, init_warp_id_o); end
        vec++; if ({init_pc_o, init_dp_addr_o, init_tblock_size_o, init_tblock_idx_o, init_tgroup_id_o}
                   !== {r_pc, r_dp, r_sz, r_ix, r_tg}) begin
          errs++; $display("FAIL st_fields c%0d got=%h/%h/%h/%h/%h want=%h/%h/%h/%h/%h", cyc,
                           init_pc_o, init_dp_addr_o, init_tblock_size_o, init_tblock_idx_o, init_tgroup_id_o,
                           r_pc, r_dp, r_sz, r_ix, r_tg);
        end
      end
      vec++; if (warp_active_o !== m_act) begin errs++; $display("FAIL st_map c%0d got=%h want=%h", cyc, warp_active_o, m_act); end
      vec++; if (active_warps_o !== 4'($countones(m_act))) begin
        errs++; $display("FAIL st_cnt c%0d got=%0d want=%0d", cyc, active_warps_o, $countones(m_act));
      end
      vec++; if (warp_free_o !== !(&m_act)) begin errs++; $display("FAIL st_free c%0d got=%b want=%b", cyc, warp_free_o, !(&m_act)); end
      hold = a && !hs;
      cyc++;
    end
    allocate_warp_i = 1'b0;
    warp_done_i     = 1'b0;
    vec++; if (reqs < 1000) begin errs++; $display("FAIL st_budget got=%0d want=1000 requests", reqs); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full_done();
    test_simul_alloc_done();
    test_spurious_done();
    test_reuse_order();
    test_wrap();
    test_stress();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
